// File: rtl/fu_issue_arbiter_pkg.sv
// Shared sizing, FU encodings and grant payload for the FU issue arbiter.
package fu_issue_arbiter_pkg;

  localparam int unsigned WF_PER_CU    = 40;
  localparam int unsigned WF_ID_LENGTH = 6;
  localparam int unsigned FU_NUM       = 4;

  // FU encodings; also used as indices into the per-FU arrays.
  localparam logic [1:0] FU_SIMD = 2'd0;
  localparam logic [1:0] FU_SALU = 2'd1;
  localparam logic [1:0] FU_LSU  = 2'd2;
  localparam logic [1:0] FU_SIMF = 2'd3;

  // Registered grant presented on one FU issue port.
  typedef struct packed {
    logic                    valid;
    logic [WF_ID_LENGTH-1:0] wfid;
  } fu_grant_t;

endpackage

// File: rtl/rr_arbiter_40.sv
// Combinational round-robin pick over a 40-entry request vector.
module rr_arbiter_40
  import fu_issue_arbiter_pkg::*;
(
  input  logic [WF_PER_CU-1:0]    req,
  input  logic [WF_ID_LENGTH-1:0] ptr,
  input  logic                    en,
  output logic                    grant_valid,
  output logic [WF_ID_LENGTH-1:0] grant_id,
  output logic [WF_ID_LENGTH-1:0] next_ptr
);

  localparam int unsigned IW = WF_ID_LENGTH + 1;

  logic [IW-1:0] base;
  logic [IW-1:0] idx;
  logic          found;

  // Scan upward from ptr with wrap at WF_PER_CU; first set request wins.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = '0;
    // An out-of-range pointer restarts the scan at slot 0.
    base = (ptr < WF_ID_LENGTH'(WF_PER_CU)) ? {1'b0, ptr} : '0;
    for (int unsigned i = 0; i < WF_PER_CU; i++) begin
      idx = base + IW'(i);
      if (idx >= IW'(WF_PER_CU)) begin
        idx = idx - IW'(WF_PER_CU);
      end
      if (!found && req[idx[WF_ID_LENGTH-1:0]]) begin
        found    = 1'b1;
        grant_id = idx[WF_ID_LENGTH-1:0];
      end
    end
    grant_valid = found & en;
    if (grant_valid) begin
      next_ptr = (grant_id == WF_ID_LENGTH'(WF_PER_CU - 1)) ? '0
                                                             : grant_id + WF_ID_LENGTH'(1);
    end else begin
      next_ptr = ptr;
    end
  end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Per-cycle issue arbiter: one wavefront per functional unit, independent RR per FU.
module fu_issue_arbiter
  import fu_issue_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_en,
  input  logic [WF_PER_CU-1:0]    wf_ready,
  input  logic [WF_PER_CU-1:0]    fu_simd,
  input  logic [WF_PER_CU-1:0]    fu_simf,
  input  logic [WF_PER_CU-1:0]    fu_salu,
  input  logic [WF_PER_CU-1:0]    fu_lsu,
  input  logic                    simd_ready,
  input  logic                    simf_ready,
  input  logic                    salu_ready,
  input  logic                    lsu_ready,
  output logic                    simd_issue_valid,
  output logic                    simf_issue_valid,
  output logic                    salu_issue_valid,
  output logic                    lsu_issue_valid,
  output logic [WF_ID_LENGTH-1:0] simd_issue_wfid,
  output logic [WF_ID_LENGTH-1:0] simf_issue_wfid,
  output logic [WF_ID_LENGTH-1:0] salu_issue_wfid,
  output logic [WF_ID_LENGTH-1:0] lsu_issue_wfid,
  output logic [WF_PER_CU-1:0]    issued_mask
);

  logic [WF_PER_CU-1:0]    excl      [FU_NUM];
  logic [WF_PER_CU-1:0]    cand      [FU_NUM];
  logic                    rdy       [FU_NUM];
  logic                    gnt_valid [FU_NUM];
  logic [WF_ID_LENGTH-1:0] gnt_id    [FU_NUM];
  logic [WF_ID_LENGTH-1:0] nxt_ptr   [FU_NUM];
  logic [WF_ID_LENGTH-1:0] ptr_q     [FU_NUM];
  fu_grant_t               grant_q   [FU_NUM];
  logic [WF_PER_CU-1:0]    block_mask;
  logic [WF_PER_CU-1:0]    grant_set;

  // FU-type exclusivity (SIMD > SIMF > SALU > LSU) and candidate masks.
  always_comb begin
    excl[FU_SIMD] = fu_simd;
    excl[FU_SIMF] = fu_simf & ~fu_simd;
    excl[FU_SALU] = fu_salu & ~fu_simd & ~fu_simf;
    excl[FU_LSU]  = fu_lsu  & ~fu_simd & ~fu_simf & ~fu_salu;
    rdy[FU_SIMD]  = simd_ready;
    rdy[FU_SIMF]  = simf_ready;
    rdy[FU_SALU]  = salu_ready;
    rdy[FU_LSU]   = lsu_ready;
    for (int unsigned f = 0; f < FU_NUM; f++) begin
      cand[f] = wf_ready & excl[f] & ~block_mask;
    end
  end

  for (genvar g = 0; g < FU_NUM; g++) begin : g_rr
    rr_arbiter_40 u_rr (
      .req         (cand[g]),
      .ptr         (ptr_q[g]),
      .en          (issue_en & rdy[g]),
      .grant_valid (gnt_valid[g]),
      .grant_id    (gnt_id[g]),
      .next_ptr    (nxt_ptr[g])
    );
  end

  // One-hot union of this cycle's grants.
  always_comb begin
    grant_set = '0;
    for (int unsigned f = 0; f < FU_NUM; f++) begin
      if (gnt_valid[f]) begin
        grant_set = grant_set | (WF_PER_CU'(1) << gnt_id[f]);
      end
    end
  end

  // Grant, pointer and block-mask registers; wfid and pointer hold without a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned f = 0; f < FU_NUM; f++) begin
        grant_q[f] <= '0;
        ptr_q[f]   <= '0;
      end
      block_mask <= '0;
    end else begin
      for (int unsigned f = 0; f < FU_NUM; f++) begin
        grant_q[f].valid <= gnt_valid[f];
        if (gnt_valid[f]) begin
          grant_q[f].wfid <= gnt_id[f];
          ptr_q[f]        <= nxt_ptr[f];
        end
      end
      block_mask <= grant_set;
    end
  end

  // block_mask is exactly the registered grant set, so it doubles as issued_mask.
  assign issued_mask      = block_mask;
  assign simd_issue_valid = grant_q[FU_SIMD].valid;
  assign simf_issue_valid = grant_q[FU_SIMF].valid;
  assign salu_issue_valid = grant_q[FU_SALU].valid;
  assign lsu_issue_valid  = grant_q[FU_LSU].valid;
  assign simd_issue_wfid  = grant_q[FU_SIMD].wfid;
  assign simf_issue_wfid  = grant_q[FU_SIMF].wfid;
  assign salu_issue_wfid  = grant_q[FU_SALU].wfid;
  assign lsu_issue_wfid   = grant_q[FU_LSU].wfid;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed self-checking bench for fu_issue_arbiter.
module tb_fu_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en;
  logic [39:0] wf_ready, fu_simd, fu_simf, fu_salu, fu_lsu;
  logic        simd_ready, simf_ready, salu_ready, lsu_ready;
  logic        simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid;
  logic [5:0]  simd_issue_wfid, simf_issue_wfid, salu_issue_wfid, lsu_issue_wfid;
  logic [39:0] issued_mask;

  int checks   = 0;
  int failures = 0;

  fu_issue_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .issue_en         (issue_en),
    .wf_ready         (wf_ready),
    .fu_simd          (fu_simd),
    .fu_simf          (fu_simf),
    .fu_salu          (fu_salu),
    .fu_lsu           (fu_lsu),
    .simd_ready       (simd_ready),
    .simf_ready       (simf_ready),
    .salu_ready       (salu_ready),
    .lsu_ready        (lsu_ready),
    .simd_issue_valid (simd_issue_valid),
    .simf_issue_valid (simf_issue_valid),
    .salu_issue_valid (salu_issue_valid),
    .lsu_issue_valid  (lsu_issue_valid),
    .simd_issue_wfid  (simd_issue_wfid),
    .simf_issue_wfid  (simf_issue_wfid),
    .salu_issue_wfid  (salu_issue_wfid),
    .lsu_issue_wfid   (lsu_issue_wfid),
    .issued_mask      (issued_mask)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs then reflect the inputs driven before it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_en   = 1'b0;
    wf_ready   = '0;
    fu_simd    = '0;
    fu_simf    = '0;
    fu_salu    = '0;
    fu_lsu     = '0;
    simd_ready = 1'b0;
    simf_ready = 1'b0;
    salu_ready = 1'b0;
    lsu_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    issue_en = 1'b1; wf_ready = '1; fu_simd = '1; fu_simf = '1; fu_salu = '1; fu_lsu = '1;
    simd_ready = 1'b1; simf_ready = 1'b1; salu_ready = 1'b1; lsu_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_valids got=%b exp=0000",
               {simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid});
    end
    checks++;
    if ({simd_issue_wfid, simf_issue_wfid, salu_issue_wfid, lsu_issue_wfid} !== 24'd0) begin
      failures++;
      $display("FAIL reset_wfids got=%h exp=0",
               {simd_issue_wfid, simf_issue_wfid, salu_issue_wfid, lsu_issue_wfid});
    end
    checks++;
    if (issued_mask !== 40'd0) begin
      failures++;
      $display("FAIL reset_issued_mask got=%h exp=0", issued_mask);
    end
    // Sole SIMD candidate wf 0 right after reset: grant visible after one edge.
    rst = 1'b0;
    clear_inputs();
    issue_en = 1'b1; wf_ready = 40'h1; fu_simd = 40'h1; simd_ready = 1'b1;
    tick();
    checks++;
    if (simd_issue_valid !== 1'b1 || simd_issue_wfid !== 6'd0) begin
      failures++;
      $display("FAIL reset_first_grant got=%b/%0d exp=1/0", simd_issue_valid, simd_issue_wfid);
    end
    checks++;
    if (issued_mask !== 40'h1) begin
      failures++;
      $display("FAIL reset_first_mask got=%h exp=1", issued_mask);
    end
  endtask

  task automatic test_rr_wrap();
    logic [5:0] exp_ids [3];
    exp_ids[0] = 6'd3; exp_ids[1] = 6'd17; exp_ids[2] = 6'd39;
    do_reset();
    issue_en = 1'b1; simd_ready = 1'b1; wf_ready = '1;
    fu_simd = (40'h1 << 3) | (40'h1 << 17) | (40'h1 << 39);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (simd_issue_valid !== 1'b1 || simd_issue_wfid !== exp_ids[k]) begin
        failures++;
        $display("FAIL rr_wrap_grant%0d got=%b/%0d exp=1/%0d", k, simd_issue_valid,
                 simd_issue_wfid, exp_ids[k]);
      end
      wf_ready = wf_ready & ~issued_mask;
    end
    // Set exhausted: no grant, wfid holds 39.
    tick();
    checks++;
    if (simd_issue_valid !== 1'b0 || simd_issue_wfid !== 6'd39) begin
      failures++;
      $display("FAIL rr_wrap_empty got=%b/%0d exp=0/39", simd_issue_valid, simd_issue_wfid);
    end
    // Reload: pointer wrapped to 0, so wf 3 is first again.
    wf_ready = '1;
    tick();
    checks++;
    if (simd_issue_valid !== 1'b1 || simd_issue_wfid !== 6'd3) begin
      failures++;
      $display("FAIL rr_wrap_reload got=%b/%0d exp=1/3", simd_issue_valid, simd_issue_wfid);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_ids [3];
    exp_ids[0] = 6'd7; exp_ids[1] = 6'd8; exp_ids[2] = 6'd7;
    do_reset();
    // wf 7 and 8 stay ready; block_mask alternates them, pointer wraps from 9 back to 7.
    issue_en = 1'b1; simd_ready = 1'b1;
    wf_ready = (40'h1 << 7) | (40'h1 << 8);
    fu_simd  = wf_ready;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (simd_issue_valid !== 1'b1 || simd_issue_wfid !== exp_ids[k]) begin
        failures++;
        $display("FAIL back_to_back_%0d got=%b/%0d exp=1/%0d", k, simd_issue_valid,
                 simd_issue_wfid, exp_ids[k]);
      end
    end
  endtask

  task automatic test_block_mask();
    logic exp_v;
    do_reset();
    issue_en = 1'b1; salu_ready = 1'b1;
    wf_ready = 40'h1 << 5; fu_salu = 40'h1 << 5;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_v = (k % 2 == 1);
      checks++;
      if (salu_issue_valid !== exp_v || salu_issue_wfid !== 6'd5) begin
        failures++;
        $display("FAIL block_mask_cycle%0d got=%b/%0d exp=%b/5", k, salu_issue_valid,
                 salu_issue_wfid, exp_v);
      end
    end
  endtask

  task automatic test_exclusivity();
    do_reset();
    issue_en = 1'b1; simd_ready = 1'b1; lsu_ready = 1'b1;
    wf_ready = 40'h1 << 9; fu_simd = 40'h1 << 9; fu_lsu = 40'h1 << 9;
    tick();
    checks++;
    if (simd_issue_valid !== 1'b1 || simd_issue_wfid !== 6'd9) begin
      failures++;
      $display("FAIL excl_simd got=%b/%0d exp=1/9", simd_issue_valid, simd_issue_wfid);
    end
    checks++;
    if (lsu_issue_valid !== 1'b0 || lsu_issue_wfid !== 6'd0) begin
      failures++;
      $display("FAIL excl_lsu got=%b/%0d exp=0/0", lsu_issue_valid, lsu_issue_wfid);
    end
    checks++;
    if (issued_mask !== (40'h1 << 9)) begin
      failures++;
      $display("FAIL excl_mask got=%h exp=%h", issued_mask, 40'h1 << 9);
    end
    // SIMF outranks SALU.
    do_reset();
    issue_en = 1'b1; simf_ready = 1'b1; salu_ready = 1'b1;
    wf_ready = 40'h1 << 9; fu_simf = 40'h1 << 9; fu_salu = 40'h1 << 9;
    tick();
    checks++;
    if (simf_issue_valid !== 1'b1 || simf_issue_wfid !== 6'd9 || salu_issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL excl_simf_salu got=simf %b/%0d salu %b exp=simf 1/9 salu 0",
               simf_issue_valid, simf_issue_wfid, salu_issue_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    issue_en = 1'b1; lsu_ready = 1'b0;
    wf_ready = 40'h1 << 12; fu_lsu = 40'h1 << 12;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (lsu_issue_valid !== 1'b0 || issued_mask !== 40'd0) begin
        failures++;
        $display("FAIL stall_lsu_%0d got=%b/%h exp=0/0", k, lsu_issue_valid, issued_mask);
      end
    end
    lsu_ready = 1'b1;
    tick();
    checks++;
    if (lsu_issue_valid !== 1'b1 || lsu_issue_wfid !== 6'd12) begin
      failures++;
      $display("FAIL stall_release got=%b/%0d exp=1/12", lsu_issue_valid, lsu_issue_wfid);
    end
    // issue_en=0 stalls all four FUs alike.
    do_reset();
    simd_ready = 1'b1; simf_ready = 1'b1; salu_ready = 1'b1; lsu_ready = 1'b1;
    wf_ready = 40'h1E; fu_simd = 40'h2; fu_simf = 40'h4; fu_salu = 40'h8; fu_lsu = 40'h10;
    issue_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid} !== 4'b0000
          || issued_mask !== 40'd0) begin
        failures++;
        $display("FAIL stall_issue_en_%0d got=%b/%h exp=0000/0", k,
                 {simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid},
                 issued_mask);
      end
    end
    issue_en = 1'b1;
    tick();
    checks++;
    if ({simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid} !== 4'b1111) begin
      failures++;
      $display("FAIL stall_issue_en_release got=%b exp=1111",
               {simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid});
    end
  endtask

  task automatic test_parallel();
    do_reset();
    issue_en = 1'b1;
    simd_ready = 1'b1; simf_ready = 1'b1; salu_ready = 1'b1; lsu_ready = 1'b1;
    wf_ready = 40'h1E; fu_simd = 40'h2; fu_simf = 40'h4; fu_salu = 40'h8; fu_lsu = 40'h10;
    tick();
    checks++;
    if ({simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid} !== 4'b1111) begin
      failures++;
      $display("FAIL parallel_valids got=%b exp=1111",
               {simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid});
    end
    checks++;
    if (simd_issue_wfid !== 6'd1 || simf_issue_wfid !== 6'd2 ||
        salu_issue_wfid !== 6'd3 || lsu_issue_wfid !== 6'd4) begin
      failures++;
      $display("FAIL parallel_wfids got=%0d,%0d,%0d,%0d exp=1,2,3,4", simd_issue_wfid,
               simf_issue_wfid, salu_issue_wfid, lsu_issue_wfid);
    end
    checks++;
    if (issued_mask !== 40'h1E) begin
      failures++;
      $display("FAIL parallel_mask got=%h exp=1e", issued_mask);
    end
    // Reset with live candidates discards the grant being formed.
    wf_ready = '1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid} !== 4'b0000 ||
        {simd_issue_wfid, simf_issue_wfid, salu_issue_wfid, lsu_issue_wfid} !== 24'd0 ||
        issued_mask !== 40'd0) begin
      failures++;
      $display("FAIL parallel_reset got=%b/%h/%h exp=0000/0/0",
               {simd_issue_valid, simf_issue_valid, salu_issue_valid, lsu_issue_valid},
               {simd_issue_wfid, simf_issue_wfid, salu_issue_wfid, lsu_issue_wfid}, issued_mask);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    test_reset();
    test_rr_wrap();
    test_back_to_back();
    test_block_mask();
    test_exclusivity();
    test_stall();
    test_parallel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
